// File: rtl/midi_msg_parser_if.sv
// Byte-fetch and message-output signal bundle for midi_msg_parser.
// master: the parser itself; slave: the upstream stage and router side.
interface midi_msg_parser_if #(
  parameter int unsigned DROP_CNT_W = 8
) ();
  logic [7:0]            midi_data;
  logic                  midi_data_rdy;
  logic                  midi_data_rd;
  logic                  msg_valid;
  logic                  msg_ack;
  logic [7:0]            msg_status;
  logic [7:0]            msg_data1;
  logic [7:0]            msg_data2;
  logic [1:0]            msg_len;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    input  midi_data, midi_data_rdy, msg_ack,
    output midi_data_rd, msg_valid, msg_status, msg_data1, msg_data2,
           msg_len, drop_cnt
  );

  modport slave (
    output midi_data, midi_data_rdy, msg_ack,
    input  midi_data_rd, msg_valid, msg_status, msg_data1, msg_data2,
           msg_len, drop_cnt
  );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream to message assembler with running status and SysEx discard.
// Define MIDI_PARSER_REALTIME_EN to emit realtime bytes (F8-FF) as len-1 messages.
module midi_msg_parser #(
  parameter int unsigned DROP_CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  midi_msg_parser_if.master bus
);

  localparam int unsigned SUM_W = DROP_CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_D1, S_D2, S_SYSEX} state_e;

  state_e                state_q, state_d;
  logic [7:0]            rs_q, rs_d;
  logic                  need2_q, need2_d;
  logic                  pend_q, pend_d;
  logic [7:0]            d1_q, d1_d;
  logic                  rd_q, rd_d;
  logic                  valid_q, valid_d;
  logic [7:0]            mstat_q, mstat_d;
  logic [7:0]            md1_q, md1_d;
  logic [7:0]            md2_q, md2_d;
  logic [1:0]            mlen_q, mlen_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  emit;
  logic [7:0]            em_stat, em_d1, em_d2;
  logic [1:0]            em_len;
  logic [1:0]            drop_inc;
  logic [7:0]            byte_v;
  logic                  chan;
  logic [SUM_W-1:0]      drop_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rs_q    <= 8'h00;
      need2_q <= 1'b0;
      pend_q  <= 1'b0;
      d1_q    <= 8'h00;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      mstat_q <= 8'h00;
      md1_q   <= 8'h00;
      md2_q   <= 8'h00;
      mlen_q  <= 2'd0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      need2_q <= need2_d;
      pend_q  <= pend_d;
      d1_q    <= d1_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      mstat_q <= mstat_d;
      md1_q   <= md1_d;
      md2_q   <= md2_d;
      mlen_q  <= mlen_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    need2_d  = need2_q;
    pend_d   = pend_q;
    d1_d     = d1_q;
    mstat_d  = mstat_q;
    md1_d    = md1_q;
    md2_d    = md2_q;
    mlen_d   = mlen_q;
    emit     = 1'b0;
    em_stat  = 8'h00;
    em_d1    = 8'h00;
    em_d2    = 8'h00;
    em_len   = 2'd0;
    drop_inc = 2'd0;
    byte_v   = bus.midi_data;
    chan     = (rs_q[7:4] != 4'hF);
    // A read is never issued back-to-back, and only when the output slot frees.
    rd_d     = bus.midi_data_rdy && !rd_q && (!valid_q || bus.msg_ack);
    valid_d  = valid_q && !bus.msg_ack;

    if (rd_q) begin
      if (byte_v >= 8'hF8) begin
`ifdef MIDI_PARSER_REALTIME_EN
        if (byte_v == 8'hF9 || byte_v == 8'hFD) begin
          drop_inc = 2'd1;
        end else begin
          emit    = 1'b1;
          em_stat = byte_v;
          em_len  = 2'd1;
        end
`endif
      end else if (!byte_v[7]) begin
        case (state_q)
          S_IDLE: drop_inc = 2'd1;
          S_D1: begin
            if (need2_q) begin
              d1_d    = byte_v;
              state_d = S_D2;
            end else begin
              emit    = 1'b1;
              em_stat = rs_q;
              em_d1   = byte_v;
              em_len  = 2'd2;
              pend_d  = 1'b0;
              state_d = chan ? S_D1 : S_IDLE;
            end
          end
          S_D2: begin
            emit    = 1'b1;
            em_stat = rs_q;
            em_d1   = d1_q;
            em_d2   = byte_v;
            em_len  = 2'd3;
            pend_d  = 1'b0;
            state_d = chan ? S_D1 : S_IDLE;
          end
          default: ;
        endcase
      end else begin
        // Any status abandons a half-built message (status latched, not yet emitted).
        if (state_q == S_D2 || (state_q == S_D1 && pend_q)) drop_inc = 2'd1;
        pend_d  = 1'b0;
        need2_d = 1'b0;
        rs_d    = 8'h00;
        state_d = S_IDLE;
        case (byte_v)
          8'hF0: state_d = S_SYSEX;
          8'hF4, 8'hF5: drop_inc = drop_inc + 2'd1;
          8'hF7: if (state_q != S_SYSEX) drop_inc = drop_inc + 2'd1;
          8'hF6: begin
            emit    = 1'b1;
            em_stat = byte_v;
            em_len  = 2'd1;
          end
          default: begin
            rs_d    = byte_v;
            pend_d  = 1'b1;
            state_d = S_D1;
            need2_d = (byte_v == 8'hF2) ||
                      (byte_v[7:5] != 3'b110 && byte_v[7:4] != 4'hF);
          end
        endcase
      end
    end

    if (emit) begin
      valid_d = 1'b1;
      mstat_d = em_stat;
      md1_d   = em_d1;
      md2_d   = em_d2;
      mlen_d  = em_len;
    end

    drop_sum = {1'b0, drop_q} + SUM_W'(drop_inc);
    drop_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  assign bus.midi_data_rd = rd_q;
  assign bus.msg_valid    = valid_q;
  assign bus.msg_status   = mstat_q;
  assign bus.msg_data1    = md1_q;
  assign bus.msg_data2    = md2_q;
  assign bus.msg_len      = mlen_q;
  assign bus.drop_cnt     = drop_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench for midi_msg_parser: byte source, auto-acking sink, per-scenario checks.
module tb_midi_msg_parser;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
  } msg_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  midi_msg_parser_if #(.DROP_CNT_W(8)) bus ();
  midi_msg_parser #(.DROP_CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  msg_t       sb[$];
  msg_t       rx[$];
  logic [7:0] txq[$];
  bit         pop_pending;
  bit         prev_rd;
  bit         ack_en;
  int         rd_pairs;
  int         total;
  int         bad;

  // One negedge step: upstream byte source, downstream sink, rd spacing monitor.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      pop_pending = 1'b0;
      bus.msg_ack = 1'b0;
    end else begin
      if (pop_pending && txq.size() != 0) void'(txq.pop_front());
      pop_pending = bus.midi_data_rd;
      if (bus.midi_data_rd && prev_rd) rd_pairs++;
      if (bus.msg_ack) begin
        bus.msg_ack = 1'b0;
      end else if (bus.msg_valid && ack_en) begin
        rx.push_back({bus.msg_status, bus.msg_data1, bus.msg_data2, bus.msg_len});
        bus.msg_ack = 1'b1;
      end
    end
    prev_rd           = bus.midi_data_rd;
    bus.midi_data_rdy = (txq.size() != 0);
    bus.midi_data     = (txq.size() != 0) ? txq[0] : 8'h00;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    txq.push_back(b);
  endtask

  task automatic expect_msg(input logic [7:0] st, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [1:0] len);
    sb.push_back({st, d1, d2, len});
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    bus.msg_ack = 1'b0;
    txq.delete();
    sb.delete();
    rx.delete();
    ack_en = 1'b1;
    run(2);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [41:0] obs;
    tick();
    rst = 1'b0;
    #1;
    obs = {bus.midi_data_rd, bus.msg_valid, bus.msg_status, bus.msg_data1,
           bus.msg_data2, bus.msg_len, bus.drop_cnt};
    total++;
    if (obs !== 42'd0) begin
      bad++;
      $display("FAIL reset_in: got %h want 0", obs);
    end
    do_reset();
    obs = {bus.midi_data_rd, bus.msg_valid, bus.msg_status, bus.msg_data1,
           bus.msg_data2, bus.msg_len, bus.drop_cnt};
    total++;
    if (obs !== 42'd0) begin
      bad++;
      $display("FAIL reset_out: got %h want 0", obs);
    end
  endtask

  task automatic test_note();
    msg_t e, g;
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64);
    expect_msg(8'h90, 8'h3C, 8'h64, 2'd3);
    run(20);
    total++;
    if (rx.size() != sb.size()) begin
      bad++;
      $display("FAIL note_count: got %0d want %0d", rx.size(), sb.size());
    end
    while (sb.size() != 0 && rx.size() != 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL note_msg: got %h want %h", g, e); end
    end
    total++;
    if (bus.drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL note_drop: got %0d want 0", bus.drop_cnt);
    end
  endtask

  task automatic test_running_status();
    msg_t e, g;
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50);
    expect_msg(8'h90, 8'h3C, 8'h64, 2'd3);
    expect_msg(8'h90, 8'h3E, 8'h50, 2'd3);
    send(8'hC5); send(8'h07); send(8'h08);
    expect_msg(8'hC5, 8'h07, 8'h00, 2'd2);
    expect_msg(8'hC5, 8'h08, 8'h00, 2'd2);
    run(40);
    total++;
    if (rx.size() != sb.size()) begin
      bad++;
      $display("FAIL running_count: got %0d want %0d", rx.size(), sb.size());
    end
    while (sb.size() != 0 && rx.size() != 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL running_msg: got %h want %h", g, e); end
    end
  endtask

  task automatic test_realtime();
    msg_t e, g;
    int   want_drop;
    do_reset();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64); send(8'hF9);
`ifdef MIDI_PARSER_REALTIME_EN
    expect_msg(8'hF8, 8'h00, 8'h00, 2'd1);
    want_drop = 1;
`else
    want_drop = 0;
`endif
    expect_msg(8'h90, 8'h3C, 8'h64, 2'd3);
    run(30);
    total++;
    if (rx.size() != sb.size()) begin
      bad++;
      $display("FAIL realtime_count: got %0d want %0d", rx.size(), sb.size());
    end
    while (sb.size() != 0 && rx.size() != 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL realtime_msg: got %h want %h", g, e); end
    end
    total++;
    if (int'(bus.drop_cnt) != want_drop) begin
      bad++;
      $display("FAIL realtime_drop: got %0d want %0d", bus.drop_cnt, want_drop);
    end
  endtask

  task automatic test_sysex_and_common();
    msg_t e, g;
    do_reset();
    send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h3C);
    send(8'hF6);
    send(8'hF2); send(8'h10); send(8'h20); send(8'h30);
    send(8'hF1); send(8'h05); send(8'h06);
    send(8'hF4);
    send(8'hF0); send(8'h01); send(8'h90); send(8'h3C); send(8'h64);
    send(8'h3E); send(8'hC0); send(8'h05);
    expect_msg(8'hF6, 8'h00, 8'h00, 2'd1);
    expect_msg(8'hF2, 8'h10, 8'h20, 2'd3);
    expect_msg(8'hF1, 8'h05, 8'h00, 2'd2);
    expect_msg(8'h90, 8'h3C, 8'h64, 2'd3);
    expect_msg(8'hC0, 8'h05, 8'h00, 2'd2);
    run(90);
    total++;
    if (rx.size() != sb.size()) begin
      bad++;
      $display("FAIL syscom_count: got %0d want %0d", rx.size(), sb.size());
    end
    while (sb.size() != 0 && rx.size() != 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL syscom_msg: got %h want %h", g, e); end
    end
    // 3C after SysEx, 30, 06, F4, and the 90/3E abandoned by C0.
    total++;
    if (bus.drop_cnt !== 8'd5) begin
      bad++;
      $display("FAIL syscom_drop: got %0d want 5", bus.drop_cnt);
    end
  endtask

  task automatic test_backpressure();
    msg_t e, g, held, cur;
    int   waited, rd_seen;
    bit   stable;
    do_reset();
    ack_en = 1'b0;
    send(8'h80); send(8'h40); send(8'h00); send(8'hB0); send(8'h07); send(8'h7F);
    expect_msg(8'h80, 8'h40, 8'h00, 2'd3);
    expect_msg(8'hB0, 8'h07, 8'h7F, 2'd3);
    waited = 0;
    while (!bus.msg_valid && waited < 40) begin tick(); waited++; end
    total++;
    if (bus.msg_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_timeout: got valid=%b want 1", bus.msg_valid);
    end
    held = {bus.msg_status, bus.msg_data1, bus.msg_data2, bus.msg_len};
    rd_seen = 0;
    stable  = 1'b1;
    repeat (20) begin
      tick();
      if (bus.midi_data_rd) rd_seen++;
      cur = {bus.msg_status, bus.msg_data1, bus.msg_data2, bus.msg_len};
      if (cur !== held || !bus.msg_valid) stable = 1'b0;
    end
    total++;
    if (rd_seen != 0) begin bad++; $display("FAIL bp_rd: got %0d reads want 0", rd_seen); end
    total++;
    if (!stable) begin bad++; $display("FAIL bp_stable: got unstable want stable"); end
    total++;
    if (txq.size() != 3) begin
      bad++;
      $display("FAIL bp_queued: got %0d bytes left want 3", txq.size());
    end
    ack_en = 1'b1;
    run(40);
    total++;
    if (rx.size() != sb.size()) begin
      bad++;
      $display("FAIL bp_count: got %0d want %0d", rx.size(), sb.size());
    end
    while (sb.size() != 0 && rx.size() != 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL bp_msg: got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [41:0] obs;
    do_reset();
    ack_en = 1'b0;
    send(8'h90); send(8'h3C); send(8'h64);
    run(20);
    rst = 1'b0;
    #1;
    obs = {bus.midi_data_rd, bus.msg_valid, bus.msg_status, bus.msg_data1,
           bus.msg_data2, bus.msg_len, bus.drop_cnt};
    total++;
    if (obs !== 42'd0) begin bad++; $display("FAIL rst_pending: got %h want 0", obs); end
    do_reset();
    send(8'h90); send(8'h3C);
    run(15);
    rst = 1'b0;
    #1;
    obs = {bus.midi_data_rd, bus.msg_valid, bus.msg_status, bus.msg_data1,
           bus.msg_data2, bus.msg_len, bus.drop_cnt};
    total++;
    if (obs !== 42'd0) begin bad++; $display("FAIL rst_d2: got %h want 0", obs); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    send(8'h64);
    run(15);
    total++;
    if (rx.size() != 0 || bus.drop_cnt !== 8'd1) begin
      bad++;
      $display("FAIL rst_state: got msgs=%0d drop=%0d want msgs=0 drop=1",
               rx.size(), bus.drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    msg_t e, g;
    do_reset();
    rd_pairs = 0;
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50);
    send(8'h41); send(8'h42);
    expect_msg(8'h90, 8'h3C, 8'h64, 2'd3);
    expect_msg(8'h90, 8'h3E, 8'h50, 2'd3);
    expect_msg(8'h90, 8'h41, 8'h42, 2'd3);
    run(40);
    total++;
    if (rx.size() != sb.size()) begin
      bad++;
      $display("FAIL b2b_count: got %0d want %0d", rx.size(), sb.size());
    end
    while (sb.size() != 0 && rx.size() != 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL b2b_msg: got %h want %h", g, e); end
    end
    total++;
    if (rd_pairs != 0) begin
      bad++;
      $display("FAIL rd_spacing: got %0d consecutive reads want 0", rd_pairs);
    end
  endtask

  task automatic test_saturate();
    int waited;
    do_reset();
    for (int i = 0; i < 300; i++) send(8'h01);
    waited = 0;
    while (txq.size() != 0 && waited < 1500) begin tick(); waited++; end
    run(10);
    total++;
    if (txq.size() != 0 || bus.drop_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL drop_sat: got drop=%0d left=%0d want drop=255 left=0",
               bus.drop_cnt, txq.size());
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rd_pairs    = 0;
    ack_en      = 1'b1;
    bus.msg_ack = 1'b0;
    test_reset();
    test_note();
    test_running_status();
    test_realtime();
    test_sysex_and_common();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

- Downstream consumer of the MIDI receive stage.
- Pulls bytes over the `midi_data` / `midi_data_rdy` / `midi_data_rd` handshake and assembles them into complete channel, system-common and realtime messages.
- Resolves running status, discards SysEx payloads and malformed bytes, and presents one message at a time on a valid/ack output port for the router core.

## Interface
Parameters:
- DROP_CNT_W, 8, width of saturating dropped-byte counter

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, same domain as the receive stage
- rst  in  1  asynchronous, active-low reset
- midi_data  in  8  byte from receive stage
- midi_data_rdy  in  1  byte available upstream
- midi_data_rd  out  1  registered one-cycle read strobe to upstream
- msg_valid  out  1  message held on msg_* outputs
- msg_ack  in  1  consumer accepts message
- msg_status  out  8  status byte
- msg_data1  out  8  first data byte, 0 if unused
- msg_data2  out  8  second data byte, 0 if unused
- msg_len  out  2  total bytes in message, 1..3
- drop_cnt  out  DROP_CNT_W  saturating count of discarded bytes

## Operation
- Assembly FSM states:
  - S_IDLE: no running status.
  - S_D1: waiting for first data byte.
  - S_D2: waiting for second data byte.
  - S_SYSEX.
- The output register (msg_*) is independent of the FSM; msg_valid marks it occupied.
- Fetch: midi_data_rd is set for one cycle when all of the following hold:
  - midi_data_rdy = 1
  - midi_data_rd = 0 in the current cycle
  - (msg_valid = 0 or msg_ack = 1)
- A byte is processed at the clock edge where midi_data_rd = 1.
- Status 80-BF, E0-EF:
  - latch status, go to S_D1, need 2 data bytes
- Status C0-DF, F1, F3:
  - latch status, go to S_D1, need 1 data byte
- Status F2:
  - latch status, go to S_D1, need 2 data bytes
- Status F6:
  - emit len 1 immediately, go to S_IDLE
- F1/F2/F3/F6:
  - clear running status, so the FSM returns to S_IDLE after the message
- F0: go to S_SYSEX.
  - Data bytes there are dropped without counting.
  - F7 returns to S_IDLE.
  - Any other non-realtime status aborts SysEx and is processed normally.
- F4, F5, or a lone F7 outside SysEx: drop, drop_cnt += 1, go to S_IDLE.
- Data byte (bit7 = 0):
  - S_IDLE: drop, drop_cnt += 1.
  - S_D1 needing 1: emit len 2. Channel status: stay in S_D1 (running status); else S_IDLE.
  - S_D1 needing 2: store, go to S_D2.
  - S_D2: emit len 3. Channel status: back to S_D1; else S_IDLE.
- New status arriving in S_D2, or in S_D1 after partial data: partial message discarded, drop_cnt += 1, new status processed.
- Realtime F8-FF: see Configuration. Never alters FSM state or running status.
- msg_valid stays high with msg_* stable until msg_ack is sampled high; it then clears in that same cycle.
- drop_cnt saturates at all-ones.

## Timing
- Reset values:
  - midi_data_rd = 0, msg_valid = 0
  - msg_status / msg_data1 / msg_data2 = 0, msg_len = 0
  - drop_cnt = 0
  - FSM = S_IDLE, running status cleared
- Reset mid-message discards everything, including any pending output.
- Edge E1: midi_data_rdy sampled high → midi_data_rd high in cycle E1..E2.
- Edge E2: byte consumed → msg_valid high after E2 if the message is complete.
- midi_data_rd never high on two consecutive cycles. Upstream drops rdy within one cycle of rd; rdy is ignored in the rd-high cycle.
- Earliest next rd: cycle after E3.
- msg_ack high while msg_valid is high at edge Ek → msg_valid low after Ek, unless the same edge is E2 of a new completing byte, in which case new msg_* are loaded and msg_valid stays high.
- No fetch while msg_valid = 1 and msg_ack = 0. Backpressure stalls upstream.

## Configuration
- MIDI_PARSER_REALTIME_EN defined:
  - realtime F8-FF (except undefined F9, FD) is emitted as a len 1 message in any FSM state without disturbing it.
  - F9/FD: drop, count.
- Not defined: all F8-FF bytes are silently consumed, not counted, and no message is emitted.

## Test plan
- 90 3C 64 → one message: status 90, d1 3C, d2 64, len 3; drop_cnt 0.
- 90 3C 64 3E 50 → two len-3 messages with status 90 (running status); second has d1 3E, d2 50.
- C5 07 08 → two len-2 messages (C5,07) and (C5,08).
- 90 3C F8 64 with REALTIME_EN → F8 len 1 first, then 90 3C 64 len 3. Without the macro → only 90 3C 64.
- F0 7E 01 F7 3C → no messages from SysEx; trailing 3C dropped, drop_cnt = 1.
- msg_ack held low for 20 cycles after 80 40 00 with B0 07 7F queued → midi_data_rd stays 0. After ack, second message delivered intact. Also assert reset during S_D2 → all outputs return to reset values.
